// File: rtl/keypad_scan_ctrl.sv
// Scan, debounce and event controller for the 12-key launchpad keypad.
// Drives the key mux select, pauses on a pressed key, emits press/release pulses.
module keypad_scan_ctrl #(
   parameter int unsigned SCAN_DIV     = 4,
   parameter int unsigned DEBOUNCE_CNT = 3
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       ENABLE,
   input  logic       KEY_IN,
   output logic [3:0] KEY_SEL,
   output logic [3:0] KEY_CODE,
   output logic       KEY_VALID,
   output logic       KEY_HELD,
   output logic       KEY_RELEASE
);

   localparam int unsigned     DivW    = $clog2(SCAN_DIV);
   localparam int unsigned     CntW    = $clog2(DEBOUNCE_CNT + 1);
   localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
   localparam logic [CntW-1:0] CntDone = CntW'(DEBOUNCE_CNT);
   localparam logic [CntW-1:0] CntOne  = CntW'(1);

   typedef enum logic [1:0] {StScan, StConfirm, StHeld} state_e;

   state_e          state_q;
   logic [DivW-1:0] div_q;
   logic [CntW-1:0] cnt_q;
   logic [3:0]      cand_q;

   logic            sample;
   logic [CntW-1:0] cnt_inc;
   logic [3:0]      sel_next;
   logic [3:0]      cand_next;

   // Sample on the last cycle of a slot so the mux output has settled.
   assign sample    = ENABLE && (div_q == DivLast);
   assign cnt_inc   = cnt_q + CntOne;
   assign sel_next  = (KEY_SEL == 4'd11) ? 4'd0 : KEY_SEL + 4'd1;
   assign cand_next = (cand_q == 4'd11) ? 4'd0 : cand_q + 4'd1;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q     <= StScan;
         div_q       <= '0;
         cnt_q       <= '0;
         cand_q      <= '0;
         KEY_SEL     <= '0;
         KEY_CODE    <= '0;
         KEY_VALID   <= 1'b0;
         KEY_HELD    <= 1'b0;
         KEY_RELEASE <= 1'b0;
      end else begin
         KEY_VALID   <= 1'b0;
         KEY_RELEASE <= 1'b0;
         if (!ENABLE) begin
            // Park: forget any partial debounce, keep the select and last code.
            state_q  <= StScan;
            div_q    <= '0;
            cnt_q    <= '0;
            KEY_HELD <= 1'b0;
         end else begin
            div_q <= (div_q == DivLast) ? '0 : div_q + DivW'(1);
            if (sample) begin
               case (state_q)
                  StScan: begin
                     if (KEY_IN) begin
                        cand_q <= KEY_SEL;
                        if (CntOne == CntDone) begin
                           KEY_CODE  <= KEY_SEL;
                           KEY_VALID <= 1'b1;
                           KEY_HELD  <= 1'b1;
                           cnt_q     <= '0;
                           state_q   <= StHeld;
                        end else begin
                           cnt_q   <= CntOne;
                           state_q <= StConfirm;
                        end
                     end else begin
                        KEY_SEL <= sel_next;
                     end
                  end
                  StConfirm: begin
                     if (KEY_IN) begin
                        if (cnt_inc == CntDone) begin
                           KEY_CODE  <= cand_q;
                           KEY_VALID <= 1'b1;
                           KEY_HELD  <= 1'b1;
                           cnt_q     <= '0;
                           state_q   <= StHeld;
                        end else begin
                           cnt_q <= cnt_inc;
                        end
                     end else begin
                        cnt_q   <= '0;
                        KEY_SEL <= cand_next;
                        state_q <= StScan;
                     end
                  end
                  StHeld: begin
                     // Any high sample restarts the release count.
                     if (KEY_IN) begin
                        cnt_q <= '0;
                     end else if (cnt_inc == CntDone) begin
                        KEY_RELEASE <= 1'b1;
                        KEY_HELD    <= 1'b0;
                        cnt_q       <= '0;
                        KEY_SEL     <= cand_next;
                        state_q     <= StScan;
                     end else begin
                        cnt_q <= cnt_inc;
                     end
                  end
                  default: state_q <= StScan;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl: default instance plus a fast
// SCAN_DIV=2 / DEBOUNCE_CNT=1 instance for the single-sample path.
module tb_keypad_scan_ctrl;

   logic       clk;
   logic       rst;
   logic       enable;
   logic       key_in;
   logic [3:0] sel;
   logic [3:0] code;
   logic       valid;
   logic       held;
   logic       release_p;

   logic       f_rst;
   logic       f_enable;
   logic       f_key;
   logic [3:0] f_sel;
   logic [3:0] f_code;
   logic       f_valid;
   logic       f_held;
   logic       f_release;

   logic       press_en;
   logic [3:0] press_key;

   int checks;
   int failures;
   int edge_n;

   keypad_scan_ctrl u_dut (
      .CLK         (clk),
      .RST         (rst),
      .ENABLE      (enable),
      .KEY_IN      (key_in),
      .KEY_SEL     (sel),
      .KEY_CODE    (code),
      .KEY_VALID   (valid),
      .KEY_HELD    (held),
      .KEY_RELEASE (release_p)
   );

   keypad_scan_ctrl #(
      .SCAN_DIV     (2),
      .DEBOUNCE_CNT (1)
   ) u_dut_fast (
      .CLK         (clk),
      .RST         (f_rst),
      .ENABLE      (f_enable),
      .KEY_IN      (f_key),
      .KEY_SEL     (f_sel),
      .KEY_CODE    (f_code),
      .KEY_VALID   (f_valid),
      .KEY_HELD    (f_held),
      .KEY_RELEASE (f_release)
   );

   // The keypad: only the pressed key reads high, and only when selected.
   assign key_in = press_en && (sel == press_key);
   assign f_key  = (f_sel == 4'd0);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      edge_n++;
   endtask

   // Return just after edge k (edge 0 = first edge with RST high).
   task automatic advance_to(input int k);
      while (edge_n <= k) tick();
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      edge_n    = 0;
      rst       = 1'b0;
      enable    = 1'b1;
      press_en  = 1'b1;
      press_key = 4'd5;
      f_rst     = 1'b0;
      f_enable  = 1'b1;

      repeat (2) @(posedge clk);
      #1;
      check("rst_sel", sel, 4'd0);
      check("rst_code", code, 4'd0);
      check("rst_valid", {3'b0, valid}, 4'd0);
      check("rst_held", {3'b0, held}, 4'd0);
      check("rst_release", {3'b0, release_p}, 4'd0);
      rst    = 1'b1;
      edge_n = 0;

      // 1: key 5 sampled at 23, 27, 31; VALID only after edge 31.
      advance_to(19);
      check("t1_sel_reach5", sel, 4'd5);
      advance_to(27);
      check("t1_sel_paused", sel, 4'd5);
      advance_to(30);
      check("t1_no_valid_early", {3'b0, valid}, 4'd0);
      check("t1_not_held_early", {3'b0, held}, 4'd0);
      advance_to(31);
      check("t1_valid", {3'b0, valid}, 4'd1);
      check("t1_code", code, 4'd5);
      check("t1_held", {3'b0, held}, 4'd1);
      advance_to(32);
      check("t1_valid_one_cycle", {3'b0, valid}, 4'd0);
      check("t1_sel_stays", sel, 4'd5);

      // 2: release over samples 35, 39, 43.
      press_en = 1'b0;
      advance_to(42);
      check("t2_no_release_early", {3'b0, release_p}, 4'd0);
      check("t2_held_still", {3'b0, held}, 4'd1);
      advance_to(43);
      check("t2_release", {3'b0, release_p}, 4'd1);
      check("t2_held_off", {3'b0, held}, 4'd0);
      check("t2_sel_next", sel, 4'd6);
      check("t2_code_kept", code, 4'd5);
      advance_to(44);
      check("t2_release_one_cycle", {3'b0, release_p}, 4'd0);

      // 3: key 2 bounces high for samples 79, 83 and drops for 87.
      press_key = 4'd2;
      press_en  = 1'b1;
      advance_to(83);
      check("t3_sel_on2", sel, 4'd2);
      press_en = 1'b0;
      advance_to(86);
      check("t3_sel_hold", sel, 4'd2);
      advance_to(87);
      check("t3_sel_after_bounce", sel, 4'd3);
      check("t3_no_valid", {3'b0, valid}, 4'd0);
      check("t3_code_kept", code, 4'd5);

      // 4: key 11 pressed (samples 123, 127, 131), then low/high/low/low/low.
      press_key = 4'd11;
      press_en  = 1'b1;
      advance_to(131);
      check("t4_valid", {3'b0, valid}, 4'd1);
      check("t4_code", code, 4'd11);
      check("t4_sel", sel, 4'd11);
      advance_to(132);
      press_en = 1'b0;
      advance_to(135);
      press_en = 1'b1;
      advance_to(139);
      press_en = 1'b0;
      advance_to(147);
      check("t3_glitch_no_release", {3'b0, release_p}, 4'd0);
      check("t3_glitch_held", {3'b0, held}, 4'd1);
      advance_to(151);
      check("t3_glitch_release", {3'b0, release_p}, 4'd1);
      check("t4_sel_wrap", sel, 4'd0);
      check("t4_code_kept", code, 4'd11);

      // 4b: idle sweep, one step per 4 cycles, 0..11 then back to 0.
      for (int k = 1; k <= 12; k++) begin
         advance_to(151 + 4 * k - 1);
         check("t4_sweep_hold", sel, 4'((k - 1) % 12));
         advance_to(151 + 4 * k);
         check("t4_sweep_step", sel, 4'(k % 12));
      end

      // 5: key 7 confirmed at 239, then ENABLE drops after edge 241.
      press_key = 4'd7;
      press_en  = 1'b1;
      advance_to(239);
      check("t5_valid", {3'b0, valid}, 4'd1);
      check("t5_code", code, 4'd7);
      advance_to(241);
      enable = 1'b0;
      advance_to(242);
      check("t5_dis_held", {3'b0, held}, 4'd0);
      check("t5_dis_release", {3'b0, release_p}, 4'd0);
      check("t5_dis_sel", sel, 4'd7);
      check("t5_dis_code", code, 4'd7);
      advance_to(245);
      check("t5_dis_release_late", {3'b0, release_p}, 4'd0);
      check("t5_dis_valid_late", {3'b0, valid}, 4'd0);
      enable = 1'b1;
      advance_to(256);
      check("t5_reen_no_valid_early", {3'b0, valid}, 4'd0);
      advance_to(257);
      check("t5_reen_valid", {3'b0, valid}, 4'd1);
      check("t5_reen_held", {3'b0, held}, 4'd1);

      // 6: release 7, press 8, reset during CONFIRM after sample 277.
      press_en = 1'b0;
      advance_to(269);
      check("t6_release", {3'b0, release_p}, 4'd1);
      check("t6_sel8", sel, 4'd8);
      press_key = 4'd8;
      press_en  = 1'b1;
      advance_to(277);
      rst = 1'b0;
      advance_to(278);
      check("t6_rst_sel", sel, 4'd0);
      check("t6_rst_code", code, 4'd0);
      check("t6_rst_valid", {3'b0, valid}, 4'd0);
      check("t6_rst_held", {3'b0, held}, 4'd0);
      check("t6_rst_release", {3'b0, release_p}, 4'd0);

      // 6b: fast instance, key 0 high confirms on the first sample.
      check("f_rst_held", {3'b0, f_held}, 4'd0);
      f_rst = 1'b1;
      @(posedge clk);
      #1;
      check("f_e0_valid", {3'b0, f_valid}, 4'd0);
      @(posedge clk);
      #1;
      check("f_e1_valid", {3'b0, f_valid}, 4'd1);
      check("f_e1_held", {3'b0, f_held}, 4'd1);
      check("f_e1_sel", f_sel, 4'd0);
      @(posedge clk);
      #1;
      check("f_e2_valid", {3'b0, f_valid}, 4'd0);
      check("f_e2_held", {3'b0, f_held}, 4'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
